// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer between two processor stages.
// Outputs come straight from registered state, and in_ready has no path from out_ready.
module pipe_stage_skid #(
    parameter int CTRL_W = 5,
    parameter int DATA_W = 101,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_count
);

    // Only the legal states are encoded, so "skid valid, main invalid" cannot occur.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [CTRL_W-1:0] main_ctrl_r;
    logic [DATA_W-1:0] main_data_r;
    logic [CTRL_W-1:0] skid_ctrl_r;
    logic [DATA_W-1:0] skid_data_r;
    logic [CNT_W-1:0]  stall_count_r;

    logic main_valid_s;
    logic skid_valid_s;
    logic accept_s;
    logic drain_s;
    logic load_main_in_s;
    logic load_main_skid_s;
    logic load_skid_in_s;

    assign main_valid_s = (state_r == ST_ONE) || (state_r == ST_FULL);
    assign skid_valid_s = (state_r == ST_FULL);
    assign in_ready     = ~skid_valid_s & ~flush & ~reset;
    assign accept_s     = in_valid & in_ready;
    assign drain_s      = main_valid_s & out_ready;

    assign out_valid   = main_valid_s;
    assign out_ctrl    = main_valid_s ? main_ctrl_r : {CTRL_W{1'b0}};
    assign out_data    = main_data_r;
    assign occupancy   = {1'b0, main_valid_s} + {1'b0, skid_valid_s};
    assign stall_count = stall_count_r;

    // Next-state and register-load selection for the skid buffer.
    always_comb begin
        state_s          = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_in_s   = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    load_main_in_s = 1'b1;
                    state_s        = ST_ONE;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && drain_s) begin
                    load_main_in_s = 1'b1;
                    state_s        = ST_ONE;
                end else if (accept_s) begin
                    load_skid_in_s = 1'b1;
                    state_s        = ST_FULL;
                end else if (drain_s) begin
                    state_s = ST_EMPTY;
                end else begin
                    state_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (drain_s) begin
                    load_main_skid_s = 1'b1;
                    state_s          = ST_ONE;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: begin
                state_s = ST_EMPTY;
            end
        endcase
        // Flush drops every held entry; data registers may keep stale contents.
        if (flush) begin
            state_s          = ST_EMPTY;
            load_main_in_s   = 1'b0;
            load_main_skid_s = 1'b0;
            load_skid_in_s   = 1'b0;
        end else begin
            state_s = state_s;
        end
    end

    // State, payload registers and saturating stall counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_EMPTY;
            main_ctrl_r   <= {CTRL_W{1'b0}};
            main_data_r   <= {DATA_W{1'b0}};
            skid_ctrl_r   <= {CTRL_W{1'b0}};
            skid_data_r   <= {DATA_W{1'b0}};
            stall_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (load_main_in_s) begin
                main_ctrl_r <= in_ctrl;
                main_data_r <= in_data;
            end else if (load_main_skid_s) begin
                main_ctrl_r <= skid_ctrl_r;
                main_data_r <= skid_data_r;
            end
            if (load_skid_in_s) begin
                skid_ctrl_r <= in_ctrl;
                skid_data_r <= in_data;
            end
            if (main_valid_s && !out_ready && !(&stall_count_r)) begin
                stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed test-plan steps plus random traffic
// checked against a FIFO-queue reference model (stall counter sized to 3 bits).
module tb_pipe_stage_skid;

    localparam int CTRL_W = 5;
    localparam int DATA_W = 101;
    localparam int CNT_W  = 3;
    localparam int CNT_MAX = 7;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic              clock = 1'b0;
    logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic [DATA_W-1:0] in_data, out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_count;

    int total = 0;
    int bad   = 0;

    ent_t              q[$];
    int                m_stall = 0;
    bit                known = 1'b0;
    bit                data_known = 1'b0;
    logic [DATA_W-1:0] last_head = '0;

    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic cycle(input logic iv, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                         input logic ordy, input logic fl, input logic rs, output bit took);
        bit exp_ready, acc, drn, stalled;
        ent_t e;
        in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl; reset = rs;
        #1;
        exp_ready = !rs && !fl && (q.size() < 2);
        acc = iv && exp_ready;
        drn = (q.size() > 0) && ordy;
        stalled = (q.size() > 0) && !ordy;
        if (known) begin
            chk("in_ready", in_ready, exp_ready);
            chk("out_valid", out_valid, q.size() > 0);
            chk("occupancy", occupancy, q.size());
            chk("stall_count", stall_count, m_stall);
            if (q.size() > 0) begin
                chk("out_ctrl", out_ctrl, q[0].c);
                chk("out_data", out_data, q[0].d);
            end else begin
                chk("out_ctrl_masked", out_ctrl, 0);
                if (data_known) chk("out_data_idle", out_data, last_head);
            end
        end
        @(posedge clock);
        #1;
        took = acc;
        if (rs) begin
            q.delete();
            m_stall = 0;
            known = 1'b1;
            data_known = 1'b1;
            last_head = '0;
        end else begin
            if (stalled && m_stall < CNT_MAX) m_stall++;
            if (drn) void'(q.pop_front());
            if (fl) begin
                q.delete();
                data_known = 1'b0;
            end else if (acc) begin
                e.c = c; e.d = d;
                q.push_back(e);
            end
        end
        if (q.size() > 0) begin
            last_head = q[0].d;
            data_known = 1'b1;
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        return w[DATA_W-1:0];
    endfunction

    initial begin
        bit t;
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
        logic iv, ordy, fl, rs;

        // Reset, then stream 1..4 with downstream always ready.
        cycle(1'b0, 5'd0, '0, 1'b0, 1'b0, 1'b1, t);
        cycle(1'b0, 5'd0, '0, 1'b0, 1'b0, 1'b1, t);
        for (int i = 1; i <= 4; i++) begin
            d = DATA_W'(i);
            cycle(1'b1, 5'(i), d, 1'b1, 1'b0, 1'b0, t);
        end
        cycle(1'b0, 5'd0, '0, 1'b1, 1'b0, 1'b0, t);
        cycle(1'b0, 5'd0, '0, 1'b1, 1'b0, 1'b0, t);

        // Backpressure: 10, 11 fill the buffer; 12 waits upstream until accepted.
        cycle(1'b1, 5'd1, 101'd10, 1'b0, 1'b0, 1'b0, t);
        cycle(1'b1, 5'd2, 101'd11, 1'b0, 1'b0, 1'b0, t);
        t = 1'b0;
        for (int i = 0; i < 6 && !t; i++)
            cycle(1'b1, 5'd3, 101'd12, (i >= 2), 1'b0, 1'b0, t);
        chk("entry12_accepted", t, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 5'd0, '0, 1'b1, 1'b0, 1'b0, t);

        // Control masking with invalid input, then a valid entry drained with no follow-up.
        cycle(1'b0, 5'b10101, 101'd99, 1'b1, 1'b0, 1'b0, t);
        cycle(1'b1, 5'b10101, 101'd77, 1'b1, 1'b0, 1'b0, t);
        cycle(1'b0, 5'b10101, 101'd0, 1'b1, 1'b0, 1'b0, t);
        cycle(1'b0, 5'b10101, 101'd0, 1'b1, 1'b0, 1'b0, t);

        // Flush while FULL, then a fresh entry flows normally.
        cycle(1'b1, 5'd7, 101'd20, 1'b0, 1'b0, 1'b0, t);
        cycle(1'b1, 5'd8, 101'd21, 1'b0, 1'b0, 1'b0, t);
        cycle(1'b1, 5'd9, 101'd22, 1'b0, 1'b1, 1'b0, t);
        cycle(1'b1, 5'd10, 101'd23, 1'b1, 1'b0, 1'b0, t);
        cycle(1'b0, 5'd0, '0, 1'b1, 1'b0, 1'b0, t);
        cycle(1'b0, 5'd0, '0, 1'b1, 1'b0, 1'b0, t);

        // Stall counter saturation, survival across flush, cleared by reset.
        cycle(1'b0, 5'd0, '0, 1'b1, 1'b0, 1'b1, t);
        cycle(1'b1, 5'd4, 101'd30, 1'b0, 1'b0, 1'b0, t);
        for (int i = 0; i < 10; i++) cycle(1'b0, 5'd0, '0, 1'b0, 1'b0, 1'b0, t);
        cycle(1'b0, 5'd0, '0, 1'b0, 1'b1, 1'b0, t);
        cycle(1'b0, 5'd0, '0, 1'b0, 1'b0, 1'b0, t);
        chk("stall_held_after_flush", stall_count, 3'd7);
        cycle(1'b0, 5'd0, '0, 1'b0, 1'b0, 1'b1, t);
        cycle(1'b0, 5'd0, '0, 1'b0, 1'b0, 1'b0, t);

        // Reset mid-operation: fill, toggle out_ready, hold reset two cycles.
        cycle(1'b1, 5'd5, 101'd40, 1'b0, 1'b0, 1'b0, t);
        cycle(1'b1, 5'd6, 101'd41, 1'b0, 1'b0, 1'b0, t);
        cycle(1'b1, 5'd7, 101'd42, 1'b1, 1'b0, 1'b0, t);
        cycle(1'b1, 5'd7, 101'd42, 1'b0, 1'b0, 1'b0, t);
        cycle(1'b1, 5'd7, 101'd43, 1'b1, 1'b0, 1'b1, t);
        cycle(1'b1, 5'd7, 101'd43, 1'b0, 1'b0, 1'b1, t);
        cycle(1'b0, 5'd0, '0, 1'b1, 1'b0, 1'b0, t);
        chk("post_reset_out_data", out_data, 0);

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 24) == 0);
            rs   = ($urandom_range(0, 79) == 0);
            c    = 5'($urandom);
            d    = rnd_data();
            cycle(iv, c, d, ordy, fl, rs, t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generalised, parametrised successor to the fixed-field pipeline registers between RISC-V pipeline stages (ID/EX, EX/MEM, MEM/WB).
- Carries an opaque control vector and a data payload between two stages using a valid/ready handshake.
- Uses a 2-entry skid buffer, so a downstream stall never drops data and never needs a combinational ready path through the stage.
- Adds flush with bubble insertion, control masking on invalid slots, occupancy reporting and a saturating stall counter.

Parameters:
- CTRL_W, 5, width of control vector (e.g. RegWrite, ResultSrc, MemWrite); forced to zero whenever the slot is invalid.
- DATA_W, 101, width of data payload (e.g. ALUResult, WriteData, Rd, PCPlus4 concatenated).
- CNT_W, 16, width of stall counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries at the next edge.
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  stage can accept an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage presents an entry.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  control bits; all zero when out_valid=0.
- out_data  out  DATA_W  payload of the head entry.
- occupancy  out  2  held entries: 0, 1 or 2.
- stall_count  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage: a main register (head, drives outputs) and a skid register, each with its own valid bit. State is EMPTY, ONE (main valid) or FULL (main and skid valid). The state "skid valid, main invalid" is illegal and must never occur.
- Transfer definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready = ~skid_valid & ~flush & ~reset. This is a function of registered state plus flush/reset only; it has no path from out_ready.
- out_valid = main_valid. out_ctrl = main_ctrl when main_valid, else 0. out_data = main_data, unmasked.
- EMPTY:
  - accept: main <= in, go to ONE.
  - otherwise: stay EMPTY.
- ONE:
  - accept & drain: main <= in, stay ONE.
  - accept & ~drain: skid <= in, go to FULL.
  - ~accept & drain: go to EMPTY.
  - neither: hold.
- FULL:
  - in_ready=0, so no accept is possible.
  - drain: main <= skid, skid invalid, go to ONE.
  - otherwise: hold.
- Ordering is strict FIFO. Latency from accept to out_valid is 1 cycle when the stage is EMPTY, or when it is ONE with a simultaneous drain.
- Sustained throughput is 1 entry/cycle while out_ready=1.
- Flush (reset=0, flush=1):
  - Next edge: both valid bits cleared, state EMPTY.
  - in_ready is 0 in the flush cycle, so nothing is accepted.
  - A drain in the flush cycle still completes, since downstream consumed it.
  - Data registers may retain stale values; the control output is masked regardless.
  - stall_count is not affected by flush.
- Reset (synchronous, highest priority):
  - Next edge: valid bits, control and data registers and stall_count all 0.
  - During reset: in_ready=0.
  - After reset: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_count=0, in_ready=1.
  - Reset asserted mid-transfer discards all held entries.
- occupancy = main_valid + skid_valid, registered-state derived.
- stall_count:
  - Increments by 1 at each edge where out_valid & ~out_ready.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by reset.
- No combinational path from in_* to out_*.

Test Plan:
- Reset then stream: reset 2 cycles, then in_valid=1 with in_data=1,2,3,4 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 one cycle later each; in_ready stays 1; occupancy stays at 1; stall_count=0.
- Backpressure skid: stream 10,11,12 with out_ready=0 from cycle 1 -> occupancy 1 then 2; in_ready=0 while FULL; entry 12 is held upstream. Release out_ready -> 10,11,12 appear in order, with nothing lost or duplicated.
- Control masking: in_ctrl=5'b10101 with in_valid=0 -> out_ctrl=0. Valid entry, then drain with no new input -> out_ctrl returns to 0 the cycle after the drain.
- Flush while FULL: hold 2 entries, pulse flush 1 cycle -> in_ready=0 that cycle; next cycle out_valid=0, occupancy=0, out_ctrl=0; next accepted entry appears normally.
- Stall counter saturation with CNT_W=3: out_valid=1, out_ready=0 for 10 cycles -> stall_count reads 1..7 then holds at 7. A flush leaves it at 7; reset clears it to 0.
- Reset mid-operation: FULL state with out_ready toggling, assert reset -> next edge all outputs at reset values and in_ready=0 while reset is held.
